// File: rtl/axi4lite_mem_responder.sv
// axi4lite_mem_responder
//   AXI4-Lite responder for a 64-bit data port: a RAM_WORDS x 64-bit RAM
//   window starting at BASE_ADDR plus one tohost MMIO word at TOHOST_ADDR.
//   Any other address answers DECERR (read data 0, write discarded).
//   One outstanding read and one outstanding write; AW and W may arrive in
//   either order. A committed tohost write raises debug_valid for one cycle,
//   and debug_bits then holds tohost[31:0] until the next tohost write.
// Ports
//   clock, reset                  rising-edge clock, synchronous active-high reset
//   io_ar_* / io_r_*              read address / read data channels
//   io_aw_* / io_w_* / io_b_*     write address / data / response channels
//   debug_valid, debug_bits       tohost write pulse and held low word
module axi4lite_mem_responder #(
  parameter int unsigned RAM_WORDS   = 4096,
  parameter logic [63:0] BASE_ADDR   = 64'h0,
  parameter logic [63:0] TOHOST_ADDR = 64'h8000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_ar_valid,
  input  logic [63:0] io_ar_bits_addr,
  input  logic [2:0]  io_ar_bits_prot,
  output logic        io_ar_ready,
  output logic        io_r_valid,
  output logic [63:0] io_r_bits_data,
  output logic [2:0]  io_r_bits_resp,
  input  logic        io_r_ready,
  input  logic        io_aw_valid,
  input  logic [63:0] io_aw_bits_addr,
  input  logic [2:0]  io_aw_bits_prot,
  output logic        io_aw_ready,
  input  logic        io_w_valid,
  input  logic [63:0] io_w_bits_data,
  input  logic [7:0]  io_w_bits_strb,
  output logic        io_w_ready,
  output logic        io_b_valid,
  output logic [2:0]  io_b_bits_resp,
  input  logic        io_b_ready,
  output logic        debug_valid,
  output logic [31:0] debug_bits
);

  localparam int unsigned IDX_W = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [2:0]  RESP_OKAY   = 3'd0;
  localparam logic [2:0]  RESP_DECERR = 3'd3;

  typedef enum logic [1:0] {DEC_RAM, DEC_TOHOST, DEC_ERR} dec_e;
  typedef enum logic       {R_IDLE, R_RESP} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_e;

  // Decode on the word address only; the byte offset within a word is ignored.
  function automatic dec_e decode(input logic [63:0] a);
    logic [60:0] woff;
    woff = a[63:3] - BASE_ADDR[63:3];
    if ((a[63:3] >= BASE_ADDR[63:3]) && (woff < 61'(RAM_WORDS))) return DEC_RAM;
    if (a[63:3] == TOHOST_ADDR[63:3]) return DEC_TOHOST;
    return DEC_ERR;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [63:0] a);
    logic [60:0] woff;
    woff = a[63:3] - BASE_ADDR[63:3];
    return woff[IDX_W-1:0];
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old_w,
                                        input logic [63:0] new_w,
                                        input logic [7:0]  strb);
    logic [63:0] r;
    r = old_w;
    for (int unsigned b = 0; b < 8; b++)
      if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  logic [63:0] mem [RAM_WORDS];

  r_state_e    r_state_q;
  logic        ar_ready_q;
  logic        r_valid_q;
  logic [63:0] r_data_q;
  logic [2:0]  r_resp_q;

  w_state_e    w_state_q;
  logic        aw_ready_q;
  logic        w_ready_q;
  logic        b_valid_q;
  logic [2:0]  b_resp_q;
  logic [63:0] aw_addr_q;
  logic [63:0] w_data_q;
  logic [7:0]  w_strb_q;
  logic [63:0] tohost_q;
  logic        debug_valid_q;
  logic [31:0] debug_bits_q;

  logic            wr_commit_d;
  logic [63:0]     wr_addr_d;
  logic [63:0]     wr_data_d;
  logic [7:0]      wr_strb_d;
  dec_e            wr_dec;
  logic [IDX_W-1:0] wr_idx;
  logic [63:0]     tohost_d;
  dec_e            rd_dec;
  logic [IDX_W-1:0] rd_idx;

  logic unused_prot;
  assign unused_prot = ^{io_ar_bits_prot, io_aw_bits_prot};

  assign rd_dec = decode(io_ar_bits_addr);
  assign rd_idx = word_idx(io_ar_bits_addr);

  // ---------------- read channel ----------------
  // RAM read happens on the AR handshake edge, so a write committed on the
  // same edge is not yet visible (read-first).
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state_q  <= R_IDLE;
      ar_ready_q <= 1'b1;
      r_valid_q  <= 1'b0;
      r_data_q   <= '0;
      r_resp_q   <= RESP_OKAY;
    end else begin
      unique case (r_state_q)
        R_IDLE: begin
          if (io_ar_valid) begin
            r_state_q  <= R_RESP;
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b1;
            unique case (rd_dec)
              DEC_RAM: begin
                r_data_q <= mem[rd_idx];
                r_resp_q <= RESP_OKAY;
              end
              DEC_TOHOST: begin
                r_data_q <= tohost_q;
                r_resp_q <= RESP_OKAY;
              end
              default: begin
                r_data_q <= '0;
                r_resp_q <= RESP_DECERR;
              end
            endcase
          end
        end
        R_RESP: begin
          if (io_r_ready) begin
            r_state_q  <= R_IDLE;
            ar_ready_q <= 1'b1;
            r_valid_q  <= 1'b0;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  // ---------------- write channel ----------------
  // The commit sources whichever half was latched earlier from its holding
  // register and the other half straight from the bus.
  always_comb begin
    wr_commit_d = 1'b0;
    wr_addr_d   = io_aw_bits_addr;
    wr_data_d   = io_w_bits_data;
    wr_strb_d   = io_w_bits_strb;
    unique case (w_state_q)
      W_IDLE:    wr_commit_d = io_aw_valid && io_w_valid;
      W_HAVE_AW: begin
        wr_commit_d = io_w_valid;
        wr_addr_d   = aw_addr_q;
      end
      W_HAVE_W:  begin
        wr_commit_d = io_aw_valid;
        wr_data_d   = w_data_q;
        wr_strb_d   = w_strb_q;
      end
      default:   wr_commit_d = 1'b0;
    endcase
  end

  assign wr_dec   = decode(wr_addr_d);
  assign wr_idx   = word_idx(wr_addr_d);
  assign tohost_d = merge(tohost_q, wr_data_d, wr_strb_d);

  always_ff @(posedge clock) begin
    if (reset) begin
      w_state_q     <= W_IDLE;
      aw_ready_q    <= 1'b1;
      w_ready_q     <= 1'b1;
      b_valid_q     <= 1'b0;
      b_resp_q      <= RESP_OKAY;
      aw_addr_q     <= '0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
      tohost_q      <= '0;
      debug_valid_q <= 1'b0;
      debug_bits_q  <= '0;
    end else begin
      debug_valid_q <= 1'b0;
      if (wr_commit_d) begin
        w_state_q  <= W_RESP;
        aw_ready_q <= 1'b0;
        w_ready_q  <= 1'b0;
        b_valid_q  <= 1'b1;
        b_resp_q   <= (wr_dec == DEC_ERR) ? RESP_DECERR : RESP_OKAY;
        if (wr_dec == DEC_TOHOST) begin
          tohost_q      <= tohost_d;
          debug_valid_q <= 1'b1;
          debug_bits_q  <= tohost_d[31:0];
        end
      end else begin
        unique case (w_state_q)
          W_IDLE: begin
            if (io_aw_valid) begin
              w_state_q  <= W_HAVE_AW;
              aw_ready_q <= 1'b0;
              aw_addr_q  <= io_aw_bits_addr;
            end else if (io_w_valid) begin
              w_state_q <= W_HAVE_W;
              w_ready_q <= 1'b0;
              w_data_q  <= io_w_bits_data;
              w_strb_q  <= io_w_bits_strb;
            end
          end
          W_RESP: begin
            if (io_b_ready) begin
              w_state_q  <= W_IDLE;
              aw_ready_q <= 1'b1;
              w_ready_q  <= 1'b1;
              b_valid_q  <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // RAM contents are never reset; writes are suppressed while reset is high.
  always_ff @(posedge clock) begin
    if (!reset && wr_commit_d && (wr_dec == DEC_RAM)) begin
      for (int unsigned b = 0; b < 8; b++)
        if (wr_strb_d[b]) mem[wr_idx][8*b +: 8] <= wr_data_d[8*b +: 8];
    end
  end

  assign io_ar_ready    = ar_ready_q;
  assign io_r_valid     = r_valid_q;
  assign io_r_bits_data = r_data_q;
  assign io_r_bits_resp = r_resp_q;
  assign io_aw_ready    = aw_ready_q;
  assign io_w_ready     = w_ready_q;
  assign io_b_valid     = b_valid_q;
  assign io_b_bits_resp = b_resp_q;
  assign debug_valid    = debug_valid_q;
  assign debug_bits     = debug_bits_q;

endmodule

// File: tb/tb_axi4lite_mem_responder.sv
// Testbench for axi4lite_mem_responder: directed steps followed by a random
// phase, checked against a word-level memory/tohost model.
module tb_axi4lite_mem_responder;

  localparam int unsigned RAM_WORDS = 256;
  localparam logic [63:0] TOHOST    = 64'h8000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ar_valid = 1'b0;
  logic [63:0] ar_addr = '0;
  logic [2:0]  ar_prot = '0;
  logic        ar_ready;
  logic        r_valid;
  logic [63:0] r_data;
  logic [2:0]  r_resp;
  logic        r_ready = 1'b0;
  logic        aw_valid = 1'b0;
  logic [63:0] aw_addr = '0;
  logic [2:0]  aw_prot = '0;
  logic        aw_ready;
  logic        w_valid = 1'b0;
  logic [63:0] w_data = '0;
  logic [7:0]  w_strb = '0;
  logic        w_ready;
  logic        b_valid;
  logic [2:0]  b_resp;
  logic        b_ready = 1'b0;
  logic        dbg_valid;
  logic [31:0] dbg_bits;

  int total = 0;
  int bad   = 0;

  logic [63:0] model_mem [RAM_WORDS];
  logic [63:0] model_tohost = '0;

  always #5 clock = ~clock;

  axi4lite_mem_responder #(
    .RAM_WORDS  (RAM_WORDS),
    .BASE_ADDR  (64'h0),
    .TOHOST_ADDR(TOHOST)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .io_ar_valid    (ar_valid),
    .io_ar_bits_addr(ar_addr),
    .io_ar_bits_prot(ar_prot),
    .io_ar_ready    (ar_ready),
    .io_r_valid     (r_valid),
    .io_r_bits_data (r_data),
    .io_r_bits_resp (r_resp),
    .io_r_ready     (r_ready),
    .io_aw_valid    (aw_valid),
    .io_aw_bits_addr(aw_addr),
    .io_aw_bits_prot(aw_prot),
    .io_aw_ready    (aw_ready),
    .io_w_valid     (w_valid),
    .io_w_bits_data (w_data),
    .io_w_bits_strb (w_strb),
    .io_w_ready     (w_ready),
    .io_b_valid     (b_valid),
    .io_b_bits_resp (b_resp),
    .io_b_ready     (b_ready),
    .debug_valid    (dbg_valid),
    .debug_bits     (dbg_bits)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // 0 = RAM, 1 = tohost, 2 = undecoded
  function automatic int kind_of(input logic [63:0] a);
    if (a < 64'(8 * RAM_WORDS)) return 0;
    if ((a >> 3) == (TOHOST >> 3)) return 1;
    return 2;
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n,
                                        input logic [7:0] s);
    logic [63:0] r;
    r = o;
    for (int i = 0; i < 8; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  // order: 0 = AW and W together, 1 = AW first, 2 = W first; gap = idle cycles between
  task automatic do_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                          input int order, input int gap, input int bdelay);
    int k;
    logic [2:0] er;
    k  = kind_of(a);
    er = (k == 2) ? 3'd3 : 3'd0;
    check("aw_ready_idle", 64'(aw_ready), 64'd1);
    check("w_ready_idle", 64'(w_ready), 64'd1);
    aw_addr = a; w_data = d; w_strb = s; aw_prot = 3'($urandom);
    if (order == 0) begin
      aw_valid = 1'b1; w_valid = 1'b1;
      step();
      aw_valid = 1'b0; w_valid = 1'b0;
    end else begin
      if (order == 1) aw_valid = 1'b1; else w_valid = 1'b1;
      step();
      aw_valid = 1'b0; w_valid = 1'b0;
      check("hold_aw_ready", 64'(aw_ready), (order == 1) ? 64'd0 : 64'd1);
      check("hold_w_ready", 64'(w_ready), (order == 1) ? 64'd1 : 64'd0);
      check("hold_no_b", 64'(b_valid), 64'd0);
      repeat (gap) step();
      aw_addr = (order == 2) ? a : 64'hDEAD_BEEF_0000_0000;
      w_data  = (order == 1) ? d : ~d;
      w_strb  = (order == 1) ? s : ~s;
      if (order == 1) w_valid = 1'b1; else aw_valid = 1'b1;
      step();
      aw_valid = 1'b0; w_valid = 1'b0;
    end
    if (k == 0) model_mem[int'(a >> 3)] = merge(model_mem[int'(a >> 3)], d, s);
    if (k == 1) model_tohost = merge(model_tohost, d, s);
    check("b_valid_latency", 64'(b_valid), 64'd1);
    check("b_resp", 64'(b_resp), 64'(er));
    check("dbg_pulse", 64'(dbg_valid), (k == 1) ? 64'd1 : 64'd0);
    if (k == 1) check("dbg_bits", 64'(dbg_bits), 64'(model_tohost[31:0]));
    for (int i = 0; i < bdelay; i++) begin
      step();
      check("b_stall_valid", 64'(b_valid), 64'd1);
      check("b_stall_resp", 64'(b_resp), 64'(er));
      check("b_stall_readys", 64'({aw_ready, w_ready}), 64'd0);
      check("dbg_one_cycle", 64'(dbg_valid), 64'd0);
    end
    b_ready = 1'b1;
    step();
    b_ready = 1'b0;
    check("b_drop", 64'(b_valid), 64'd0);
    check("w_readys_back", 64'({aw_ready, w_ready}), 64'd3);
    check("dbg_low", 64'(dbg_valid), 64'd0);
  endtask

  task automatic do_read(input logic [63:0] a, input int rdelay, output logic [63:0] got);
    int k;
    logic [63:0] ed;
    logic [2:0] er;
    k  = kind_of(a);
    ed = (k == 0) ? model_mem[int'(a >> 3)] : (k == 1) ? model_tohost : 64'd0;
    er = (k == 2) ? 3'd3 : 3'd0;
    check("ar_ready_idle", 64'(ar_ready), 64'd1);
    ar_addr = a; ar_prot = 3'($urandom); ar_valid = 1'b1;
    step();
    ar_valid = 1'b0;
    ar_addr  = 64'hFFFF_0000_FFFF_0000;
    got = r_data;
    check("r_valid_latency", 64'(r_valid), 64'd1);
    check("r_data", r_data, ed);
    check("r_resp", 64'(r_resp), 64'(er));
    check("ar_ready_busy", 64'(ar_ready), 64'd0);
    for (int i = 0; i < rdelay; i++) begin
      step();
      check("r_stall_valid", 64'(r_valid), 64'd1);
      check("r_stall_data", r_data, ed);
      check("r_stall_resp", 64'(r_resp), 64'(er));
      check("r_stall_ready", 64'(ar_ready), 64'd0);
    end
    r_ready = 1'b1;
    step();
    r_ready = 1'b0;
    check("r_drop", 64'(r_valid), 64'd0);
    check("ar_ready_back", 64'(ar_ready), 64'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_readys"}, 64'({ar_ready, aw_ready, w_ready}), 64'd7);
    check({tag, "_valids"}, 64'({r_valid, b_valid, dbg_valid}), 64'd0);
    check({tag, "_resps"}, 64'({r_resp, b_resp}), 64'd0);
    check({tag, "_rdata"}, r_data, 64'd0);
    check({tag, "_dbg_bits"}, 64'(dbg_bits), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] got;
    logic [63:0] a;
    int kind;

    // reset state
    reset = 1'b1;
    repeat (3) step();
    check_reset_state("reset");
    reset = 1'b0;
    step();

    // preload words 0..15 so the model knows every word later read
    for (int i = 0; i < 16; i++)
      do_write(64'(8 * i), {$urandom, $urandom}, 8'hFF, 0, 0, 0);

    // full write then read back at 0x10
    do_write(64'h10, 64'h1122_3344_5566_7788, 8'hFF, 0, 0, 0);
    do_read(64'h10, 0, got);
    check("t1_data", got, 64'h1122_3344_5566_7788);

    // W three cycles before AW, low-half strobes
    do_write(64'h10, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F, 2, 2, 0);
    do_read(64'h10, 0, got);
    check("t2_merge", got, 64'h1122_3344_BBBB_BBBB);

    // AW first with gap, byte offset in address ignored
    do_write(64'h1D, 64'h0102_0304_0506_0708, 8'hA5, 1, 3, 1);
    do_read(64'h18, 0, got);

    // both responses stalled five cycles, concurrently
    fork
      do_read(64'h10, 5, got);
      do_write(64'h20, 64'hCAFE_F00D_1234_5678, 8'hFF, 0, 0, 5);
    join

    // same-edge read and write of one word: read returns pre-write data
    fork
      do_read(64'h28, 0, got);
      do_write(64'h28, 64'h5555_6666_7777_8888, 8'hFF, 0, 0, 0);
    join
    do_read(64'h28, 0, got);
    check("rf_after", got, 64'h5555_6666_7777_8888);

    // tohost
    do_write(TOHOST, 64'h1, 8'hFF, 0, 0, 0);
    check("th_bits_held", 64'(dbg_bits), 64'h1);
    do_read(TOHOST, 0, got);
    check("th_read", got, 64'h1);
    do_write(TOHOST + 64'h4, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 0, 0, 0);
    check("th_strb0_bits", 64'(dbg_bits), 64'h1);

    // first address past the RAM window
    do_write(64'(8 * RAM_WORDS), 64'hBAD0_BAD0_BAD0_BAD0, 8'hFF, 0, 0, 0);
    do_read(64'(8 * RAM_WORDS), 0, got);
    check("decerr_rdata", got, 64'd0);
    do_read(64'h0, 0, got);

    // reset while R_RESP and W_HAVE_AW
    ar_addr = 64'h10; ar_valid = 1'b1;
    step();
    ar_valid = 1'b0;
    aw_addr = 64'h30; aw_valid = 1'b1;
    step();
    aw_valid = 1'b0;
    check("pre_rst_rvalid", 64'(r_valid), 64'd1);
    check("pre_rst_awready", 64'(aw_ready), 64'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_reset_state("midrst");
    model_tohost = '0;
    repeat (2) step();
    check("midrst_quiet", 64'({r_valid, b_valid}), 64'd0);
    do_read(TOHOST, 0, got);
    do_read(64'h10, 0, got);

    // random phase
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 6)      a = 64'(8 * $urandom_range(0, 15) + $urandom_range(0, 7));
      else if (kind <= 8) a = TOHOST + 64'($urandom_range(0, 7));
      else                a = 64'(8 * RAM_WORDS + 8 * $urandom_range(0, 100));
      if ($urandom_range(0, 1) == 0)
        do_read(a, $urandom_range(0, 3), got);
      else
        do_write(a, {$urandom, $urandom}, 8'($urandom), $urandom_range(0, 2),
                 $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
